// File: rtl/spi_nor_read_ctrl.sv
// SPI NOR fast-read controller: CMD/ADDR/DUMMY/DATA sequencing, SCK at clk/2.
// CSB is held low after a read so the next sequential read can stream on directly.
module spi_nor_read_ctrl #(
  parameter logic [7:0] CMD_READ     = 8'h0B,
  parameter int         DUMMY_CYCLES = 15,
  parameter int         IDLE_TIMEOUT = 64,
  parameter int         CSB_HIGH_MIN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [23:0] addr,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        resp,
  output logic [31:0] rdata,
  output logic        nor_sck,
  output logic        nor_csb,
  output logic        nor_si,
  input  logic        nor_so
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, HOLD, DESEL} state_t;

  state_t      state, state_n;
  logic        sck_q, sck_n, csb_q, csb_n, busy_q, busy_n, resp_q, resp_n;
  logic [31:0] rdata_q, rdata_n, rx_q, rx_n, sh_q, sh_n;
  logic [23:0] addr_q, addr_n, next_q, next_n, load_addr;
  logic [2:0]  nbytes_q, nbytes_n;
  logic [15:0] cnt_q, cnt_n;
  logic [5:0]  nbits;
  logic        go_cmd;

  function automatic logic [2:0] decode_size(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign nbits = {nbytes_q, 3'b000};

  always_comb begin
    state_n   = state;
    sck_n     = sck_q;
    csb_n     = csb_q;
    busy_n    = busy_q;
    resp_n    = 1'b0;
    rdata_n   = rdata_q;
    rx_n      = rx_q;
    sh_n      = sh_q;
    addr_n    = addr_q;
    next_n    = next_q;
    nbytes_n  = nbytes_q;
    cnt_n     = cnt_q;
    go_cmd    = 1'b0;
    load_addr = addr_q;
    case (state)
      IDLE: begin
        if (req) begin
          addr_n    = addr;
          nbytes_n  = decode_size(size);
          busy_n    = 1'b1;
          go_cmd    = 1'b1;
          load_addr = addr;
        end
      end
      CMD, ADDR, DUMMY: begin
        sck_n = ~sck_q;
        // The shifter empties to zero, so nor_si is 0 through DUMMY without extra logic.
        if (sck_q) begin
          sh_n  = {sh_q[30:0], 1'b0};
          cnt_n = cnt_q + 16'd1;
          if (state == CMD && cnt_q == 16'd7) begin
            state_n = ADDR;
            cnt_n   = 16'd0;
          end else if (state == ADDR && cnt_q == 16'd23) begin
            state_n = DUMMY;
            cnt_n   = 16'd0;
          end else if (state == DUMMY && cnt_q == 16'(DUMMY_CYCLES - 1)) begin
            state_n = DATA;
            cnt_n   = 16'd0;
            rx_n    = 32'd0;
          end
        end
      end
      DATA: begin
        if (cnt_q == {10'd0, nbits}) begin
          resp_n  = 1'b1;
          busy_n  = 1'b0;
          rdata_n = rx_q;
          next_n  = addr_q + {21'd0, nbytes_q};
          state_n = HOLD;
          cnt_n   = 16'd0;
        end else begin
          sck_n = ~sck_q;
          // Bit b goes to byte b/8, MSB first within the byte.
          if (!sck_q) rx_n[{cnt_q[4:3], ~cnt_q[2:0]}] = nor_so;
          else        cnt_n = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (req) begin
          addr_n   = addr;
          nbytes_n = decode_size(size);
          busy_n   = 1'b1;
          cnt_n    = 16'd0;
          if (addr == next_q) begin
            state_n = DATA;
            rx_n    = 32'd0;
          end else begin
            state_n = DESEL;
            csb_n   = 1'b1;
          end
        end else if (cnt_q == 16'(IDLE_TIMEOUT - 1)) begin
          state_n = DESEL;
          csb_n   = 1'b1;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      DESEL: begin
        if (cnt_q == 16'(CSB_HIGH_MIN - 1)) begin
          if (busy_q) begin
            go_cmd = 1'b1;
          end else if (req) begin
            addr_n    = addr;
            nbytes_n  = decode_size(size);
            busy_n    = 1'b1;
            go_cmd    = 1'b1;
            load_addr = addr;
          end else begin
            state_n = IDLE;
            cnt_n   = 16'd0;
          end
        end else begin
          cnt_n = cnt_q + 16'd1;
          if (req && !busy_q) begin
            addr_n   = addr;
            nbytes_n = decode_size(size);
            busy_n   = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (go_cmd) begin
      state_n = CMD;
      csb_n   = 1'b0;
      sck_n   = 1'b0;
      sh_n    = {CMD_READ, load_addr};
      cnt_n   = 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sck_q    <= 1'b0;
      csb_q    <= 1'b1;
      busy_q   <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= 32'd0;
      rx_q     <= 32'd0;
      sh_q     <= 32'd0;
      addr_q   <= 24'd0;
      next_q   <= 24'd0;
      nbytes_q <= 3'd1;
      cnt_q    <= 16'd0;
    end else begin
      state    <= state_n;
      sck_q    <= sck_n;
      csb_q    <= csb_n;
      busy_q   <= busy_n;
      resp_q   <= resp_n;
      rdata_q  <= rdata_n;
      rx_q     <= rx_n;
      sh_q     <= sh_n;
      addr_q   <= addr_n;
      next_q   <= next_n;
      nbytes_q <= nbytes_n;
      cnt_q    <= cnt_n;
    end
  end

  assign busy    = busy_q;
  assign resp    = resp_q;
  assign rdata   = rdata_q;
  assign nor_sck = sck_q;
  assign nor_csb = csb_q;
  assign nor_si  = sh_q[31];

endmodule

// File: tb/tb_spi_nor_read_ctrl.sv
// Bench for spi_nor_read_ctrl: serial flash model, transaction-level latency/data model,
// directed scenarios followed by randomized reads.
module tb_spi_nor_read_ctrl;
  localparam int DUMMY   = 15;
  localparam int TIMEOUT = 64;
  localparam int CSB_MIN = 4;
  localparam int FRESH = 0, CONT = 1, NONSEQ = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [23:0] addr = 24'd0;
  logic [1:0]  size = 2'd0;
  logic        busy, resp, nor_sck, nor_csb, nor_si;
  logic [31:0] rdata;
  logic        nor_so = 1'b0;

  int n_checks = 0, n_errors = 0, viol = 0;
  int cs_falls = 0, seen_session = 0, fbits = 0;
  logic [31:0] fsh = 32'd0;
  logic [7:0]  cap_cmd = 8'd0;
  logic [23:0] cap_addr = 24'd0;

  bit          model_hold = 1'b0;
  logic [23:0] model_next = 24'd0;
  logic [31:0] last_data = 32'd0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  spi_nor_read_ctrl #(
    .CMD_READ(8'h0B), .DUMMY_CYCLES(DUMMY), .IDLE_TIMEOUT(TIMEOUT), .CSB_HIGH_MIN(CSB_MIN)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .size(size),
    .busy(busy), .resp(resp), .rdata(rdata),
    .nor_sck(nor_sck), .nor_csb(nor_csb), .nor_si(nor_si), .nor_so(nor_so)
  );

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a < 24'd16) return a[3:0] * 8'h11;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Flash: counts SCK rising edges per CSB session, streams bytes from the captured address.
  always @(negedge nor_csb) cs_falls++;

  always @(posedge nor_sck) begin
    if (!nor_csb) begin
      if (seen_session != cs_falls) begin
        fbits = 0;
        seen_session = cs_falls;
      end
      if (fbits < 32) fsh = {fsh[30:0], nor_si};
      fbits++;
      if (fbits == 32) begin
        cap_cmd  = fsh[31:24];
        cap_addr = fsh[23:0];
      end
    end
  end

  always @(negedge nor_sck) begin
    int j;
    logic [7:0] b;
    if (!nor_csb && fbits >= 32 + DUMMY) begin
      j = fbits - 32 - DUMMY;
      b = mem_byte(cap_addr + 24'(j / 8));
      nor_so = b[7 - j % 8];
    end
  end

  // Pin-level rules: SCK low while deselected, SI moves only on SCK fall or CSB fall, resp one cycle.
  logic prev_sck = 1'b0, prev_csb = 1'b1, prev_si = 1'b0, prev_resp = 1'b0;
  always @(posedge clk) begin
    logic rst_at_edge;
    rst_at_edge = rst;
    #1;
    if (!rst_at_edge) begin
      if (nor_csb && nor_sck) viol++;
      if (nor_si !== prev_si && !(prev_sck && !nor_sck) && !(prev_csb && !nor_csb)) viol++;
      if (resp && prev_resp) viol++;
    end
    prev_sck  = nor_sck;
    prev_csb  = nor_csb;
    prev_si   = nor_si;
    prev_resp = resp;
  end

  // Issue a read sampled k edges after the current negedge's preceding edge and check it.
  task automatic do_read(input int k, input logic [23:0] a, input logic [1:0] sz, input bit inject);
    int nb, kind, exp_lat, n, cs0;
    logic [31:0] exp_data;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (model_hold && k <= TIMEOUT) kind = (a == model_next) ? CONT : NONSEQ;
    else kind = FRESH;
    exp_lat = 2 * (32 + DUMMY + 8 * nb) + 1;
    if (kind == CONT) exp_lat = 16 * nb + 1;
    if (kind == NONSEQ) exp_lat = exp_lat + CSB_MIN;
    exp_data = 32'd0;
    for (int i = 0; i < nb; i++) exp_data = exp_data | (32'(mem_byte(a + 24'(i))) << (8 * i));
    exp_q.push_back(exp_data);

    repeat (k - 1) @(negedge clk);
    check_val("rdata_hold", rdata, last_data);
    cs0  = cs_falls;
    addr = a;
    size = sz;
    req  = 1'b1;
    @(negedge clk);
    check_val("busy_after_accept", {31'd0, busy}, 32'd1);
    n = 0;
    while (1) begin
      req = inject && (n == 3);
      if (req) begin
        addr = 24'($urandom);
        size = 2'($urandom);
      end
      @(negedge clk);
      n++;
      if (resp || n >= 600) break;
    end
    req = 1'b0;
    check_val("latency", n, exp_lat);
    check_val("rdata", rdata, exp_q.pop_front());
    check_val("busy_at_resp", {31'd0, busy}, 32'd0);
    check_val("csb_low_in_hold", {31'd0, nor_csb}, 32'd0);
    check_val("csb_sessions", cs_falls - cs0, (kind == CONT) ? 0 : 1);
    if (kind != CONT) begin
      check_val("cmd_opcode", {24'd0, cap_cmd}, 32'h0B);
      check_val("cmd_addr", {8'd0, cap_addr}, {8'd0, a});
    end
    last_data  = exp_data;
    model_hold = 1'b1;
    model_next = a + 24'(nb);
  endtask

  initial begin
    int resp_seen, k, pick;
    logic [23:0] a;

    repeat (3) @(negedge clk);
    check_val("rst_csb", {31'd0, nor_csb}, 32'd1);
    check_val("rst_sck", {31'd0, nor_sck}, 32'd0);
    check_val("rst_si", {31'd0, nor_si}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_resp", {31'd0, resp}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_read(1, 24'h000004, 2'd3, 1'b0);
    do_read(5, 24'h000008, 2'd0, 1'b0);
    do_read(3, 24'h000001, 2'd1, 1'b0);

    repeat (TIMEOUT - 1) @(negedge clk);
    check_val("csb_before_timeout", {31'd0, nor_csb}, 32'd0);
    @(negedge clk);
    check_val("csb_at_timeout", {31'd0, nor_csb}, 32'd1);
    model_hold = 1'b0;
    do_read(30, model_next, 2'd2, 1'b0);

    do_read(10, 24'hFFFFFF, 2'd0, 1'b1);
    do_read(4, 24'h000000, 2'd1, 1'b0);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) k = $urandom_range(80, 110);
      else k = $urandom_range(1, 60);
      pick = $urandom_range(0, 2);
      if (pick == 0) a = model_next;
      else if (pick == 1) a = 24'($urandom_range(0, 15));
      else a = 24'($urandom);
      do_read(k, a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (90) @(negedge clk);
    addr = 24'h000010;
    size = 2'd3;
    req  = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (114) @(negedge clk);
    check_val("busy_before_reset", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_csb", {31'd0, nor_csb}, 32'd1);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_resp", {31'd0, resp}, 32'd0);
    check_val("abort_sck", {31'd0, nor_sck}, 32'd0);
    check_val("abort_rdata", rdata, 32'd0);
    rst = 1'b0;
    resp_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp) resp_seen++;
    end
    check_val("no_resp_after_abort", resp_seen, 0);
    model_hold = 1'b0;
    model_next = 24'd0;
    last_data  = 32'd0;
    do_read(1, 24'h000004, 2'd3, 1'b0);

    check_val("protocol_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_nor_read_ctrl.md
SPI_NOR_READ_CTRL -- requirements
Module: spi_nor_read_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- CMD_READ, 8'h0B, read opcode shifted in command phase.
- DUMMY_CYCLES, 15, SCK cycles between the last address bit and the first data bit.
- IDLE_TIMEOUT, 64, clk cycles in HOLD with no request before CSB is released.
- CSB_HIGH_MIN, 4, minimum clk cycles CSB stays high between transactions.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- req, in, 1, single-cycle read request, accepted only when busy=0.
- addr, in, 24, byte address of the first byte.
- size, in, 2, number of bytes minus one: 0=1, 1=2, 3=4; 2 is treated as 4.
- busy, out, 1, transaction in flight.
- resp, out, 1, one-cycle completion pulse.
- rdata, out, 32, read data, valid while resp=1.
- nor_sck, out, 1, SPI clock, mode 0, idle low.
- nor_csb, out, 1, chip select, active low.
- nor_si, out, 1, serial data to flash.
- nor_so, in, 1, serial data from flash.

Function
REQ-003 nor_sck SHALL run at clk/2: each SCK cycle is a low clk cycle followed by a high clk cycle, and SCK toggles only while CSB=0.
REQ-004 nor_si SHALL change only on clk edges that drive SCK high-to-low, or at CSB assertion for bit 0 of the command.
REQ-005 nor_so SHALL be sampled on the clk edge that drives SCK low-to-high.
REQ-006 The states SHALL be IDLE, CMD, ADDR, DUMMY, DATA, HOLD and DESEL.
REQ-007 In IDLE with req=1, the block SHALL latch addr/size, set busy, drive CSB low and enter CMD on the same edge.
REQ-008 CMD SHALL shift CMD_READ MSB first over 8 SCK cycles, then go to ADDR.
REQ-009 ADDR SHALL shift the 24-bit address MSB first over 24 SCK cycles, then go to DUMMY.
REQ-010 DUMMY SHALL hold nor_si=0 for DUMMY_CYCLES SCK cycles, then go to DATA.
REQ-011 DATA SHALL receive 8*N bits with each byte MSB first; byte k (the byte at addr+k) SHALL land in rdata[8k+7:8k], and unused upper bytes SHALL read 0.
REQ-012 After the last data bit the block SHALL pulse resp for exactly 1 cycle, clear busy on the same edge, advance next_addr to addr+N (mod 2^24, wrapping from 0xFFFFFF to 0x000000), and enter HOLD with CSB low and SCK low.
REQ-013 In HOLD with req=1 and addr==next_addr, the block SHALL enter DATA directly, skipping CMD/ADDR/DUMMY, and set busy.
REQ-014 In HOLD with req=1 and addr!=next_addr, the block SHALL latch the request, set busy, raise CSB and go to DESEL; after CSB_HIGH_MIN cycles it SHALL lower CSB and enter CMD.
REQ-015 In HOLD with no req for IDLE_TIMEOUT cycles, the block SHALL raise CSB and go to DESEL; after CSB_HIGH_MIN cycles it SHALL go to IDLE.
- If req arrives on the same cycle the timeout expires, req SHALL win.
REQ-016 A request in DESEL with busy=0 SHALL be accepted and SHALL start CMD once the CSB_HIGH_MIN count completes.
REQ-017 Latency from accept edge to resp edge SHALL be exactly:
- fresh from IDLE: 2*(32+DUMMY_CYCLES+8N)+1 cycles;
- sequential continuation: 16N+1 cycles;
- non-sequential from HOLD: the fresh count plus CSB_HIGH_MIN.
REQ-018 req while busy=1 SHALL be ignored, with no state change.
REQ-019 rdata SHALL hold its value until the next resp.

Reset
REQ-020 While rst=1 at a clk edge, the outputs SHALL be: nor_csb=1, nor_sck=0, nor_si=0, busy=0, resp=0, rdata=0; state SHALL be IDLE, next_addr=0 and all counters 0.
REQ-021 Reset mid-transaction SHALL abort on that edge: CSB high the next cycle, no resp, and no CSB_HIGH_MIN wait imposed after reset release.

Verification
REQ-022 Flash model with 0x00..0x0F = 00,11,...,FF:
- Scenario 1: req addr=0x000004 size=3 from IDLE -> CMD 0x0B, ADDR 000004, rdata=0x77665544, resp 2*(32+15+32)+1=159 cycles after accept.
- Scenario 2: then req addr=0x000008 size=0 within the timeout -> no CSB toggle, rdata=0x00000088, resp 17 cycles after accept.
- Scenario 3: then req addr=0x000001 size=1 -> CSB high for 4 cycles, new CMD/ADDR, rdata=0x00002211.
- Scenario 4: idle 64 cycles in HOLD -> CSB rises on cycle 64; a following sequential-address req performs a full CMD/ADDR/DUMMY.
- Scenario 5: req addr=0xFFFFFF size=0, then req addr=0x000000 -> the second is a continuation (next_addr wrap).
- Scenario 6: assert rst in DATA bit 10 -> CSB=1 and busy=0 the next cycle, no resp; the next req completes normally.
